// File: rtl/shared_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : shared_mem_arbiter
//  Purpose  : Round-robin core arbiter for the shared data RAM, with absolute
//             priority for the host bus-transfer loader.
//  Revision : 1.0  initial release
// ============================================================================
module shared_mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int AW        = 16,
    parameter int DW        = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CORES-1:0]    core_req,
    input  logic [NUM_CORES-1:0]    core_we,
    input  logic [NUM_CORES*AW-1:0] core_addr,
    input  logic [NUM_CORES*DW-1:0] core_wdata,
    output logic [NUM_CORES-1:0]    core_gnt,
    output logic [NUM_CORES-1:0]    core_rvalid,
    output logic [DW-1:0]           core_rdata,
    input  logic                    bt_req,
    output logic                    bt_gnt,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    input  logic [DW-1:0]           mem_rdata,
    output logic [1:0]              addr_sel
);

    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [PW:0]          c_ncores = (PW+1)'(NUM_CORES);
    localparam logic [NUM_CORES-1:0] c_one    = {{(NUM_CORES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CORE_ACC = 2'd1,
        S_CORE_RD  = 2'd2,
        S_BT       = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] win_q, win_d;

    logic [PW-1:0] w_pick;
    logic          w_any;
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_inc;

    // Descending scan so the requester closest at/after rr_ptr is written last and wins.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        w_sum  = '0;
        for (int i = NUM_CORES-1; i >= 0; i--) begin
            w_sum = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (w_sum >= c_ncores) begin
                w_sum = w_sum - c_ncores;
            end
            if (core_req[w_sum[PW-1:0]]) begin
                w_pick = w_sum[PW-1:0];
                w_any  = 1'b1;
            end
        end
    end

    always_comb begin
        if (win_q == PW'(NUM_CORES-1)) begin
            w_inc = '0;
        end else begin
            w_inc = win_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        core_gnt    = '0;
        core_rvalid = '0;
        core_rdata  = '0;
        bt_gnt      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        addr_sel    = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (bt_req) begin
                    state_d = S_BT;
                end else if (w_any) begin
                    win_d   = w_pick;
                    state_d = S_CORE_ACC;
                end
            end
            S_CORE_ACC: begin
                core_gnt  = c_one << win_q;
                mem_we    = core_we[win_q];
                mem_addr  = core_addr[int'(win_q)*AW +: AW];
                mem_wdata = core_wdata[int'(win_q)*DW +: DW];
                addr_sel  = 2'b01;
                if (core_we[win_q]) begin
                    rr_ptr_d = w_inc;
                    state_d  = S_IDLE;
                end else begin
                    state_d  = S_CORE_RD;
                end
            end
            S_CORE_RD: begin
                // RAM has one cycle of read latency: data addressed in CORE_ACC lands here.
                core_rvalid = c_one << win_q;
                core_rdata  = mem_rdata;
                addr_sel    = 2'b01;
                rr_ptr_d    = w_inc;
                state_d     = S_IDLE;
            end
            S_BT: begin
                bt_gnt   = 1'b1;
                addr_sel = 2'b10;
                if (!bt_req) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_shared_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shared_mem_arbiter
//  Purpose  : Scoreboard bench for shared_mem_arbiter (grants, reads, BT priority).
//  Revision : 1.0  initial release
// ============================================================================
module tb_shared_mem_arbiter;

    localparam int NC = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NC-1:0]    core_req;
    logic [NC-1:0]    core_we;
    logic [NC*AW-1:0] core_addr;
    logic [NC*DW-1:0] core_wdata;
    logic [NC-1:0]    core_gnt;
    logic [NC-1:0]    core_rvalid;
    logic [DW-1:0]    core_rdata;
    logic             bt_req;
    logic             bt_gnt;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;
    logic [1:0]       addr_sel;

    always #5 clk = ~clk;

    shared_mem_arbiter #(.NUM_CORES(NC), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .bt_req(bt_req), .bt_gnt(bt_gnt),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .addr_sel(addr_sel)
    );

    // RAM model: unwritten locations read back as addr ^ 0x1C (0x20 -> 0x3C).
    bit [7:0] ram [256];
    bit       written [256];
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[7:0]]     <= mem_wdata;
            written[mem_addr[7:0]] <= 1'b1;
        end
        mem_rdata <= written[mem_addr[7:0]] ? ram[mem_addr[7:0]] : (mem_addr[7:0] ^ 8'h1C);
    end

    int inv_bad = 0;
    always @(negedge clk) begin
        if (!$onehot0(core_gnt) || !$onehot0(core_rvalid) || ((|core_gnt) && (|core_rvalid)) ||
            (bt_gnt !== addr_sel[1]) || (addr_sel === 2'b11) || (bt_gnt && (|core_gnt))) begin
            inv_bad++;
            $display("invariant broken at %0t: gnt=%b rvalid=%b bt_gnt=%b sel=%b",
                     $time, core_gnt, core_rvalid, bt_gnt, addr_sel);
        end
    end

    typedef struct {
        logic [NC-1:0] gnt;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    task automatic set_core(input int idx, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_we[idx]            = we;
        core_addr[idx*AW +: AW] = a;
        core_wdata[idx*DW +: DW] = d;
    endtask

    task automatic push_exp(input int idx, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] rd);
        exp_t e;
        e.gnt = '0; e.gnt[idx] = 1'b1;
        e.we = we; e.addr = a; e.wdata = d; e.rdata = rd;
        sb.push_back(e);
    endtask

    // Bounded wait (in negedges) for the next grant pulse.
    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (core_gnt == '0 && n < 8);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bt_req = 1'b1; core_req = '1;
        core_we = '0; core_addr = '0; core_wdata = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({core_gnt, core_rvalid, bt_gnt, mem_we, addr_sel} !== '0 ||
                {core_rdata, mem_addr, mem_wdata} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: gnt=%b rv=%b bt=%b we=%b sel=%b rd=%h a=%h wd=%h want all 0",
                         core_gnt, core_rvalid, bt_gnt, mem_we, addr_sel, core_rdata, mem_addr, mem_wdata);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bt_gnt, addr_sel, core_gnt} !== {1'b1, 2'b10, 4'b0000}) begin
            errors++;
            $display("FAIL reset_release_bt: bt=%b sel=%b gnt=%b want 1/10/0000", bt_gnt, addr_sel, core_gnt);
        end
        bt_req = 1'b0; core_req = '0;
        @(negedge clk);
        checks++;
        if ({bt_gnt, addr_sel} !== 3'b000) begin
            errors++;
            $display("FAIL reset_bt_exit: bt=%b sel=%b want 0/00", bt_gnt, addr_sel);
        end
    endtask

    task automatic test_fairness();
        int   n;
        int   order [6] = '{0, 1, 2, 3, 0, 1};
        exp_t e;
        for (int i = 0; i < NC; i++) set_core(i, 1'b1, 16'(16'h0100 + i), 8'(8'h50 + i));
        foreach (order[k]) push_exp(order[k], 1'b1, 16'(16'h0100 + order[k]), 8'(8'h50 + order[k]), 8'h00);
        core_req = '1;
        for (int k = 0; k < 6; k++) begin
            wait_gnt(n);
            e = sb.pop_front();
            checks++;
            if (n !== ((k == 0) ? 1 : 2)) begin
                errors++;
                $display("FAIL fair_spacing[%0d]: %0d cycles want %0d", k, n, (k == 0) ? 1 : 2);
            end
            checks++;
            if (core_gnt !== e.gnt) begin
                errors++;
                $display("FAIL fair_order[%0d]: gnt=%b want %b", k, core_gnt, e.gnt);
            end
            checks++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, e.addr, e.wdata}) begin
                errors++;
                $display("FAIL fair_bus[%0d]: we=%b a=%h d=%h want 1/%h/%h", k, mem_we, mem_addr, mem_wdata, e.addr, e.wdata);
            end
        end
        core_req = '0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        int   n;
        exp_t e;
        set_core(2, 1'b1, 16'h0010, 8'hA5);
        push_exp(2, 1'b1, 16'h0010, 8'hA5, 8'h00);
        core_req = 4'b0100;
        wait_gnt(n);
        e = sb.pop_front();
        checks++;
        if (n !== 1 || core_gnt !== e.gnt) begin
            errors++;
            $display("FAIL wr_grant: gnt=%b after %0d want %b after 1", core_gnt, n, e.gnt);
        end
        checks++;
        if ({mem_we, mem_addr, mem_wdata, addr_sel} !== {1'b1, e.addr, e.wdata, 2'b01}) begin
            errors++;
            $display("FAIL wr_bus: we=%b a=%h d=%h sel=%b want 1/%h/%h/01", mem_we, mem_addr, mem_wdata, addr_sel, e.addr, e.wdata);
        end
        core_req = '0;
        @(negedge clk);
        checks++;
        if ({addr_sel, core_gnt} !== 6'b0) begin
            errors++;
            $display("FAIL wr_done: sel=%b gnt=%b want 00/0000", addr_sel, core_gnt);
        end
    endtask

    task automatic test_single_read();
        int   n;
        exp_t e;
        set_core(1, 1'b0, 16'h0020, 8'h00);
        push_exp(1, 1'b0, 16'h0020, 8'h00, 8'h3C);
        core_req = 4'b0010;
        wait_gnt(n);
        e = sb.pop_front();
        checks++;
        if (n !== 1 || core_gnt !== e.gnt || {mem_we, mem_addr, addr_sel} !== {1'b0, e.addr, 2'b01}) begin
            errors++;
            $display("FAIL rd_grant: gnt=%b n=%0d we=%b a=%h sel=%b want %b/1/0/%h/01",
                     core_gnt, n, mem_we, mem_addr, addr_sel, e.gnt, e.addr);
        end
        core_req = '0;
        @(negedge clk);
        checks++;
        if (core_rvalid !== e.gnt || core_rdata !== e.rdata) begin
            errors++;
            $display("FAIL rd_data: rv=%b rd=%h want %b/%h", core_rvalid, core_rdata, e.gnt, e.rdata);
        end
        checks++;
        if ({mem_we, core_gnt, addr_sel} !== {1'b0, 4'b0000, 2'b01}) begin
            errors++;
            $display("FAIL rd_phase: we=%b gnt=%b sel=%b want 0/0000/01", mem_we, core_gnt, addr_sel);
        end
        @(negedge clk);
        checks++;
        if ({addr_sel, core_rvalid} !== 6'b0) begin
            errors++;
            $display("FAIL rd_done: sel=%b rv=%b want 00/0000", addr_sel, core_rvalid);
        end
    endtask

    task automatic test_bt_priority();
        int   n;
        exp_t e;
        set_core(3, 1'b1, 16'h0030, 8'h77);
        push_exp(3, 1'b1, 16'h0030, 8'h77, 8'h00);
        bt_req = 1'b1; core_req = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({bt_gnt, addr_sel, core_gnt, mem_we, mem_addr} !== {1'b1, 2'b10, 4'b0000, 1'b0, 16'h0000}) begin
                errors++;
                $display("FAIL bt_hold[%0d]: bt=%b sel=%b gnt=%b we=%b a=%h want 1/10/0000/0/0000",
                         k, bt_gnt, addr_sel, core_gnt, mem_we, mem_addr);
            end
        end
        bt_req = 1'b0;
        wait_gnt(n);
        e = sb.pop_front();
        checks++;
        if (n !== 2 || core_gnt !== e.gnt || mem_addr !== e.addr) begin
            errors++;
            $display("FAIL bt_then_core: gnt=%b n=%0d a=%h want %b/2/%h", core_gnt, n, mem_addr, e.gnt, e.addr);
        end
        core_req = '0;
        @(negedge clk);
        // Read by core 0, with BT arriving during the read-data cycle.
        set_core(0, 1'b0, 16'h0005, 8'h00);
        push_exp(0, 1'b0, 16'h0005, 8'h00, 8'h19);
        core_req = 4'b0001;
        wait_gnt(n);
        e = sb.pop_front();
        core_req = '0;
        @(negedge clk);
        checks++;
        if (core_rvalid !== e.gnt || core_rdata !== e.rdata || bt_gnt !== 1'b0) begin
            errors++;
            $display("FAIL bt_rd_first: rv=%b rd=%h bt=%b want %b/%h/0", core_rvalid, core_rdata, bt_gnt, e.gnt, e.rdata);
        end
        bt_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({addr_sel, bt_gnt} !== 3'b000) begin
            errors++;
            $display("FAIL bt_rd_idle: sel=%b bt=%b want 00/0", addr_sel, bt_gnt);
        end
        @(negedge clk);
        checks++;
        if ({bt_gnt, addr_sel} !== 3'b110) begin
            errors++;
            $display("FAIL bt_after_rd: bt=%b sel=%b want 1/10", bt_gnt, addr_sel);
        end
        bt_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        int   n;
        exp_t e;
        set_core(0, 1'b0, 16'h0006, 8'h00);
        push_exp(0, 1'b0, 16'h0006, 8'h00, 8'h1A);
        core_req = 4'b0001;
        wait_gnt(n);
        e = sb.pop_front();
        checks++;
        if (core_gnt !== e.gnt) begin
            errors++;
            $display("FAIL rst_rd_grant: gnt=%b want %b", core_gnt, e.gnt);
        end
        core_req = '0; rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({core_rvalid, addr_sel, core_gnt} !== 10'b0) begin
            errors++;
            $display("FAIL rst_rd_abort: rv=%b sel=%b gnt=%b want 0000/00/0000", core_rvalid, addr_sel, core_gnt);
        end
        rst_n = 1'b1;
        set_core(0, 1'b1, 16'h0040, 8'h11);
        set_core(1, 1'b1, 16'h0041, 8'h22);
        push_exp(0, 1'b1, 16'h0040, 8'h11, 8'h00);
        core_req = 4'b0011;
        wait_gnt(n);
        e = sb.pop_front();
        checks++;
        if (n !== 1 || core_gnt !== e.gnt || mem_addr !== e.addr) begin
            errors++;
            $display("FAIL rst_rr_ptr: gnt=%b n=%0d a=%h want %b/1/%h", core_gnt, n, mem_addr, e.gnt, e.addr);
        end
        core_req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_invariants();
        checks++;
        if (inv_bad !== 0) begin
            errors++;
            $display("FAIL invariants: %0d violating cycles want 0", inv_bad);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fairness();
        test_single_write();
        test_single_read();
        test_bt_priority();
        test_reset_mid_read();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
